// File: rtl/imem_loader_if.sv
// Host word stream into the instruction-ROM loader: valid/ready handshake carrying one word.
// The host side drives valid/data; the loader side drives ready.
interface imem_loader_if #(
  parameter int unsigned DW = 32
) ();
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-ROM program loader: streams an image into the ROM, reads it back,
// compares checksums and releases the core from reset only after a clean verify.
module imem_loader #(
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  imem_loader_if.slave  host,
  output logic          rom_we,
  output logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_wdata,
  input  logic [DW-1:0] rom_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StDone,
    StError
  } state_e;

  localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q;
  logic [DW-1:0] lsum_q;
  logic [DW-1:0] vsum_q;
  logic [DW-1:0] checksum_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          hold_q;

  logic          len_bad;
  logic          at_last;
  logic          load_hs;
  logic [DW-1:0] vsum_next;

  assign len_bad   = (len == '0) || (len > DepthLen);
  // Compare in AW+1 bits so len == DEPTH terminates at the top address without wrapping.
  assign at_last   = ({1'b0, addr_q} == (len_q - (AW + 1)'(1)));
  assign load_hs   = host.s_valid && host.s_ready;
  assign vsum_next = vsum_q + rom_rdata;

  assign host.s_ready = (state_q == StLoad);
  assign rom_we       = (state_q == StLoad) && host.s_valid;
  assign rom_addr     = addr_q;
  assign rom_wdata    = host.s_data;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = hold_q;
  assign checksum = checksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      lsum_q     <= '0;
      vsum_q     <= '0;
      checksum_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            done_q <= 1'b0;
            hold_q <= 1'b1;
            if (len_bad) begin
              state_q <= StError;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StLoad;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              len_q   <= len;
              addr_q  <= '0;
              lsum_q  <= '0;
            end
          end
        end

        StLoad: begin
          if (load_hs) begin
            lsum_q <= lsum_q + host.s_data;
            if (at_last) begin
              state_q <= StVerify;
              addr_q  <= '0;
              vsum_q  <= '0;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end

        StVerify: begin
          vsum_q <= vsum_next;
          if (at_last) begin
            checksum_q <= lsum_q;
            busy_q     <= 1'b0;
            if (vsum_next == lsum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StError;
              err_q   <= 1'b1;
            end
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          hold_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
